ram_port_arbiter: RTL and testbench

- Shares one SinglePort_RAM instance between two independent requesters (port 0 and port 1). Each request is a read or a write.
- Round-robin arbitration, one outstanding RAM access at a time.
- Sits between client logic (e.g. read/write datapath units) and the RAM.
- The RAM read path has 1-cycle registered latency: o_data updates on the edge that samples i_rd_en.

---
 rtl/ram_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin front end for a single-port RAM with 1-cycle registered reads.
// Only one RAM access is in flight at a time: IDLE arbitrates, ISSUE strobes the RAM, RESP returns read data.
module ram_port_arbiter #(
    parameter int unsigned SIZE_ADDR = 8,
    parameter int unsigned SIZE_DATA = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,

    input  logic                 i_req_0,
    input  logic                 i_we_0,
    input  logic [SIZE_ADDR-1:0] i_addr_0,
    input  logic [SIZE_DATA-1:0] i_wdata_0,

    input  logic                 i_req_1,
    input  logic                 i_we_1,
    input  logic [SIZE_ADDR-1:0] i_addr_1,
    input  logic [SIZE_DATA-1:0] i_wdata_1,

    output logic                 o_gnt_0,
    output logic                 o_gnt_1,
    output logic                 o_rvalid_0,
    output logic                 o_rvalid_1,
    output logic [SIZE_DATA-1:0] o_rdata_0,
    output logic [SIZE_DATA-1:0] o_rdata_1,

    output logic                 o_ram_rd_en,
    output logic                 o_ram_wr_en,
    output logic [SIZE_ADDR-1:0] o_ram_addr,
    output logic [SIZE_DATA-1:0] o_ram_wdata,
    input  logic [SIZE_DATA-1:0] i_ram_rdata,

    output logic                 o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    logic   rr;       // port that wins the next contended arbitration
    logic   owner;    // port of the access currently in flight

    logic   any_req_c;
    logic   win_c;

    // Winner selection: a lone requester wins, otherwise the round-robin pointer decides.
    always_comb begin
        any_req_c = i_req_0 | i_req_1;
        win_c     = 1'b0;
        if (i_req_0 && i_req_1) begin
            win_c = rr;
        end else if (i_req_1) begin
            win_c = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            rr          <= 1'b0;
            owner       <= 1'b0;
            o_gnt_0     <= 1'b0;
            o_gnt_1     <= 1'b0;
            o_rvalid_0  <= 1'b0;
            o_rvalid_1  <= 1'b0;
            o_rdata_0   <= '0;
            o_rdata_1   <= '0;
            o_ram_rd_en <= 1'b0;
            o_ram_wr_en <= 1'b0;
            o_ram_addr  <= '0;
            o_ram_wdata <= '0;
            o_busy      <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses unless re-asserted below.
            o_gnt_0     <= 1'b0;
            o_gnt_1     <= 1'b0;
            o_rvalid_0  <= 1'b0;
            o_rvalid_1  <= 1'b0;
            o_ram_rd_en <= 1'b0;
            o_ram_wr_en <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_req_c) begin
                        owner <= win_c;
                        rr    <= ~win_c;
                        if (win_c) begin
                            o_gnt_1     <= 1'b1;
                            o_ram_addr  <= i_addr_1;
                            o_ram_wdata <= i_wdata_1;
                            o_ram_wr_en <= i_we_1;
                            o_ram_rd_en <= ~i_we_1;
                        end else begin
                            o_gnt_0     <= 1'b1;
                            o_ram_addr  <= i_addr_0;
                            o_ram_wdata <= i_wdata_0;
                            o_ram_wr_en <= i_we_0;
                            o_ram_rd_en <= ~i_we_0;
                        end
                        state  <= ISSUE;
                        o_busy <= 1'b1;
                    end else begin
                        o_busy <= 1'b0;
                    end
                end

                ISSUE: begin
                    // The RAM performs the access on this edge; reads need one more cycle for data.
                    if (o_ram_wr_en) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        state  <= RESP;
                        o_busy <= 1'b1;
                    end
                end

                RESP: begin
                    if (owner) begin
                        o_rdata_1  <= i_ram_rdata;
                        o_rvalid_1 <= 1'b1;
                    end else begin
                        o_rdata_0  <= i_ram_rdata;
                        o_rvalid_0 <= 1'b1;
                    end
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural single-port RAM (1-cycle registered read).
// Expected values come from a bench-side shadow of the RAM contents and hand-derived cycle timing.
module tb_ram_port_arbiter;

    localparam int unsigned SIZE_ADDR = 8;
    localparam int unsigned SIZE_DATA = 8;

    logic                 i_clk;
    logic                 i_rst;
    logic                 i_req_0, i_req_1;
    logic                 i_we_0, i_we_1;
    logic [SIZE_ADDR-1:0] i_addr_0, i_addr_1;
    logic [SIZE_DATA-1:0] i_wdata_0, i_wdata_1;
    logic                 o_gnt_0, o_gnt_1;
    logic                 o_rvalid_0, o_rvalid_1;
    logic [SIZE_DATA-1:0] o_rdata_0, o_rdata_1;
    logic                 o_ram_rd_en, o_ram_wr_en;
    logic [SIZE_ADDR-1:0] o_ram_addr;
    logic [SIZE_DATA-1:0] o_ram_wdata;
    logic [SIZE_DATA-1:0] i_ram_rdata;
    logic                 o_busy;

    logic [SIZE_DATA-1:0] mem     [256];
    logic [SIZE_DATA-1:0] exp_mem [256];

    int n_cmp;
    int n_err;

    ram_port_arbiter #(.SIZE_ADDR(SIZE_ADDR), .SIZE_DATA(SIZE_DATA)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_0     (i_req_0),
        .i_we_0      (i_we_0),
        .i_addr_0    (i_addr_0),
        .i_wdata_0   (i_wdata_0),
        .i_req_1     (i_req_1),
        .i_we_1      (i_we_1),
        .i_addr_1    (i_addr_1),
        .i_wdata_1   (i_wdata_1),
        .o_gnt_0     (o_gnt_0),
        .o_gnt_1     (o_gnt_1),
        .o_rvalid_0  (o_rvalid_0),
        .o_rvalid_1  (o_rvalid_1),
        .o_rdata_0   (o_rdata_0),
        .o_rdata_1   (o_rdata_1),
        .o_ram_rd_en (o_ram_rd_en),
        .o_ram_wr_en (o_ram_wr_en),
        .o_ram_addr  (o_ram_addr),
        .o_ram_wdata (o_ram_wdata),
        .i_ram_rdata (i_ram_rdata),
        .o_busy      (o_busy)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Single-port RAM: write and registered read both happen on the sampling edge.
    always @(posedge i_clk) begin
        if (o_ram_wr_en) mem[o_ram_addr] <= o_ram_wdata;
        if (o_ram_rd_en) i_ram_rdata <= mem[o_ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},    32'({o_gnt_1, o_gnt_0}), 32'd0);
        chk({tag, "_rvalid"}, 32'({o_rvalid_1, o_rvalid_0}), 32'd0);
        chk({tag, "_strobe"}, 32'({o_ram_wr_en, o_ram_rd_en}), 32'd0);
        chk({tag, "_addr"},   32'(o_ram_addr), 32'd0);
        chk({tag, "_wdata"},  32'(o_ram_wdata), 32'd0);
        chk({tag, "_rdata0"}, 32'(o_rdata_0), 32'd0);
        chk({tag, "_rdata1"}, 32'(o_rdata_1), 32'd0);
        chk({tag, "_busy"},   32'(o_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, n_rv, last, port;
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i * 13 + 7);
            exp_mem[i] = 8'(i * 13 + 7);
        end
        i_ram_rdata = '0;
        i_rst = 1'b1;
        i_req_0 = 1'b0; i_we_0 = 1'b0; i_addr_0 = '0; i_wdata_0 = '0;
        i_req_1 = 1'b0; i_we_1 = 1'b0; i_addr_1 = '0; i_wdata_1 = '0;
        step(); step();
        chk_all_zero("reset");
        i_rst = 1'b0;
        step();

        // Port 0 write 0xA5 to 0x05, then port 1 reads it back.
        i_req_0 = 1'b1; i_we_0 = 1'b1; i_addr_0 = 8'h05; i_wdata_0 = 8'hA5;
        step();
        chk("w_gnt",   32'({o_gnt_1, o_gnt_0}), 32'b01);
        chk("w_wren",  32'({o_ram_wr_en, o_ram_rd_en}), 32'b10);
        chk("w_addr",  32'(o_ram_addr), 32'h05);
        chk("w_wdata", 32'(o_ram_wdata), 32'hA5);
        chk("w_busy",  32'(o_busy), 32'd1);
        i_req_0 = 1'b0;
        exp_mem[8'h05] = 8'hA5;
        step();
        chk("w_wren_off", 32'({o_ram_wr_en, o_gnt_0}), 32'd0);
        chk("w_busy_off", 32'(o_busy), 32'd0);

        i_req_1 = 1'b1; i_we_1 = 1'b0; i_addr_1 = 8'h05;
        step();
        chk("r_gnt",  32'({o_gnt_1, o_gnt_0}), 32'b10);
        chk("r_rden", 32'({o_ram_wr_en, o_ram_rd_en}), 32'b01);
        chk("r_addr", 32'(o_ram_addr), 32'h05);
        i_req_1 = 1'b0;
        step();
        chk("r_e1_rvalid", 32'(o_rvalid_1), 32'd0);
        chk("r_e1_busy",   32'({o_busy, o_ram_rd_en}), 32'b10);
        step();
        chk("r_e2_rvalid", 32'({o_rvalid_1, o_rvalid_0}), 32'b10);
        chk("r_e2_rdata",  32'(o_rdata_1), 32'(exp_mem[8'h05]));
        step();
        chk("r_after", 32'({o_rvalid_1, o_busy}), 32'd0);
        chk("r_hold",  32'(o_rdata_1), 32'hA5);

        // Both ports stream reads: grants alternate 0,1,0,1 three cycles apart.
        i_req_0 = 1'b1; i_we_0 = 1'b0; i_addr_0 = 8'h10;
        i_req_1 = 1'b1; i_we_1 = 1'b0; i_addr_1 = 8'h20;
        g = 0; n_rv = 0; last = 0;
        for (int cyc = 1; cyc <= 40 && n_rv < 4; cyc++) begin
            step();
            chk("rr_excl", 32'((o_gnt_0 & o_gnt_1) | (o_rvalid_0 & o_rvalid_1) | (o_ram_rd_en & o_ram_wr_en)), 32'd0);
            if (o_gnt_0 || o_gnt_1) begin
                port = o_gnt_1 ? 1 : 0;
                chk("rr_order", 32'(port), 32'(g % 2));
                if (g > 0) chk("rr_spacing", 32'(cyc - last), 32'd3);
                last = cyc;
                g++;
                if (g == 4) begin
                    i_req_0 = 1'b0;
                    i_req_1 = 1'b0;
                end
            end
            if (o_rvalid_0) begin chk("rr_rdata0", 32'(o_rdata_0), 32'(exp_mem[8'h10])); n_rv++; end
            if (o_rvalid_1) begin chk("rr_rdata1", 32'(o_rdata_1), 32'(exp_mem[8'h20])); n_rv++; end
        end
        chk("rr_grants", 32'(g), 32'd4);
        chk("rr_rvalids", 32'(n_rv), 32'd4);
        i_req_0 = 1'b0; i_req_1 = 1'b0;
        step();

        // Port 0 alone reads 0x00..0x09, advancing the address on each grant.
        i_req_0 = 1'b1; i_we_0 = 1'b0; i_addr_0 = 8'h00;
        g = 0; n_rv = 0; last = 0;
        for (int cyc = 1; cyc <= 60 && n_rv < 10; cyc++) begin
            step();
            if (o_gnt_0) begin
                if (g > 0) chk("seq_spacing", 32'(cyc - last), 32'd3);
                last = cyc;
                g++;
                if (g < 10) i_addr_0 = 8'(g);
                else        i_req_0 = 1'b0;
            end
            if (o_rvalid_0) begin
                chk("seq_rdata", 32'(o_rdata_0), 32'(exp_mem[n_rv]));
                n_rv++;
            end
        end
        chk("seq_grants", 32'(g), 32'd10);
        chk("seq_rvalids", 32'(n_rv), 32'd10);
        i_req_0 = 1'b0;
        step();

        // Reset for 3 cycles while a port 0 read waits in RESP; pointer was left at port 1.
        i_req_0 = 1'b1; i_we_0 = 1'b0; i_addr_0 = 8'h03;
        step();
        chk("mr_gnt", 32'(o_gnt_0), 32'd1);
        i_req_0 = 1'b0;
        step();
        i_rst = 1'b1;
        #1;
        chk_all_zero("mr_async");
        step(); step(); step();
        chk_all_zero("mr_held");
        i_rst = 1'b0;
        step();
        chk("mr_no_rvalid", 32'({o_rvalid_1, o_rvalid_0}), 32'd0);
        i_req_0 = 1'b1; i_addr_0 = 8'h11;
        i_req_1 = 1'b1; i_we_1 = 1'b0; i_addr_1 = 8'h22;
        step();
        chk("mr_first_gnt", 32'({o_gnt_1, o_gnt_0}), 32'b01);
        i_req_0 = 1'b0; i_req_1 = 1'b0;
        step(); step();
        chk("mr_rvalid", 32'({o_rvalid_1, o_rvalid_0}), 32'b01);
        chk("mr_rdata",  32'(o_rdata_0), 32'(exp_mem[8'h11]));
        step();

        // Reset while a port 1 read sits in ISSUE.
        i_req_1 = 1'b1; i_we_1 = 1'b0; i_addr_1 = 8'h30;
        step();
        chk("ri_gnt", 32'({o_gnt_1, o_ram_rd_en}), 32'b11);
        i_req_1 = 1'b0;
        i_rst = 1'b1;
        #1;
        chk("ri_rden_drop", 32'({o_gnt_1, o_ram_rd_en}), 32'd0);
        step(); step(); step();
        i_rst = 1'b0;
        n_rv = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (o_rvalid_1) n_rv++;
        end
        chk("ri_no_rvalid", 32'(n_rv), 32'd0);
        chk("ri_rdata1", 32'(o_rdata_1), 32'd0);
        i_req_0 = 1'b1; i_we_0 = 1'b0; i_addr_0 = 8'h40;
        i_req_1 = 1'b1; i_we_1 = 1'b0; i_addr_1 = 8'h41;
        step();
        chk("ri_rr0", 32'({o_gnt_1, o_gnt_0}), 32'b01);
        i_req_0 = 1'b0; i_req_1 = 1'b0;
        step(); step();
        chk("ri_rdata0", 32'(o_rdata_0), 32'(exp_mem[8'h40]));
        step();

        // Pointer now favours port 1: its write to 0x07 precedes port 0's read of 0x07.
        i_req_1 = 1'b1; i_we_1 = 1'b1; i_addr_1 = 8'h07; i_wdata_1 = 8'h3C;
        i_req_0 = 1'b1; i_we_0 = 1'b0; i_addr_0 = 8'h07;
        step();
        chk("wr_first_gnt", 32'({o_gnt_1, o_gnt_0}), 32'b10);
        chk("wr_first_en",  32'({o_ram_wr_en, o_ram_rd_en}), 32'b10);
        chk("wr_first_dat", 32'(o_ram_wdata), 32'h3C);
        i_req_1 = 1'b0;
        exp_mem[8'h07] = 8'h3C;
        step();
        chk("wr_e1_gnt0", 32'(o_gnt_0), 32'd0);
        step();
        chk("rd_after_gnt", 32'({o_gnt_1, o_gnt_0, o_ram_rd_en}), 32'b011);
        i_req_0 = 1'b0;
        step(); step();
        chk("rd_after_rvalid", 32'(o_rvalid_0), 32'd1);
        chk("rd_after_rdata",  32'(o_rdata_0), 32'(exp_mem[8'h07]));
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
